// File: rtl/mem_beat_bridge.sv
// mem_beat_bridge
//
// Splits one cache-line memory request from the L1 arbiter into NBEATS
// narrow beats on the external bus, then rebuilds the line from the read
// responses and returns it with a single-cycle response pulse.
//
// Optional feature macro: MEM_BRIDGE_STATS_EN
//   defined   -> 64-bit read/write completed-line counters
//   undefined -> stat_rd_lines / stat_wr_lines tied to zero, no counter flops
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   mem_req_valid            line request, held until mem_rsp_valid
//   mem_req_addr             line byte address (low offset bits ignored)
//   mem_req_opcode           4'd4 line read, 4'd7 line write
//   mem_req_store_data       line to write
//   mem_rsp_valid            one-cycle response pulse
//   mem_rsp_load_data        assembled read line
//   bus_req_valid/ready      beat handshake
//   bus_req_addr/we/wdata    beat address, direction, write data
//   bus_rsp_valid/rdata      in-order beat responses (read data or ack)
//   proto_err                sticky protocol error flag
//   stat_rd_lines/wr_lines   completed line counters
module mem_beat_bridge #(
    parameter int CL_BITS   = 128,
    parameter int BEAT_BITS = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    input  logic [ADDR_W-1:0]    mem_req_addr,
    input  logic [3:0]           mem_req_opcode,
    input  logic [CL_BITS-1:0]   mem_req_store_data,
    output logic                 mem_rsp_valid,
    output logic [CL_BITS-1:0]   mem_rsp_load_data,
    output logic                 bus_req_valid,
    input  logic                 bus_req_ready,
    output logic [ADDR_W-1:0]    bus_req_addr,
    output logic                 bus_req_we,
    output logic [BEAT_BITS-1:0] bus_req_wdata,
    input  logic                 bus_rsp_valid,
    input  logic [BEAT_BITS-1:0] bus_rsp_rdata,
    output logic                 proto_err,
    output logic [63:0]          stat_rd_lines,
    output logic [63:0]          stat_wr_lines
);

    localparam int NBEATS     = CL_BITS / BEAT_BITS;
    localparam int BEAT_BYTES = BEAT_BITS / 8;
    localparam int LINE_BYTES = CL_BITS / 8;
    localparam int CNT_W      = $clog2(NBEATS + 1);

    localparam logic [3:0] OP_RD = 4'd4;
    localparam logic [3:0] OP_WR = 4'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 op_we_r;
    logic [CL_BITS-1:0]   store_r;
    logic [CNT_W-1:0]     issue_cnt_r;
    logic [CNT_W-1:0]     rsp_cnt_r;
    logic [CL_BITS-1:0]   line_r;
    logic                 proto_err_r;
    logic                 rsp_valid_r;
    logic                 bus_valid_r;
    logic [ADDR_W-1:0]    bus_addr_r;
    logic                 bus_we_r;
    logic [BEAT_BITS-1:0] bus_wdata_r;

    logic                 legal_s;
    logic                 accept_s;
    logic                 last_issue_s;
    logic                 outstanding_s;
    logic                 rsp_take_s;
    logic                 unsolicited_s;
    logic                 rsp_done_s;

    // Select beat idx out of a full line.
    function automatic logic [BEAT_BITS-1:0] beat_of(input logic [CL_BITS-1:0] line,
                                                     input logic [CNT_W-1:0]   idx);
        logic [BEAT_BITS-1:0] res;
        res = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (idx == CNT_W'(i)) begin
                res = line[i*BEAT_BITS +: BEAT_BITS];
            end
        end
        return res;
    endfunction

    assign legal_s       = (mem_req_opcode == OP_RD) || (mem_req_opcode == OP_WR);
    assign accept_s      = (state_r == ISSUE) && bus_valid_r && bus_req_ready;
    assign last_issue_s  = accept_s && (issue_cnt_r == CNT_W'(NBEATS - 1));
    // Counters only differ while beats are in flight; equal counts mean any
    // response is unsolicited.
    assign outstanding_s = (issue_cnt_r != rsp_cnt_r);
    assign rsp_take_s    = bus_rsp_valid && outstanding_s &&
                           ((state_r == ISSUE) || (state_r == DRAIN));
    assign unsolicited_s = bus_rsp_valid && !rsp_take_s;
    assign rsp_done_s    = (rsp_cnt_r == CNT_W'(NBEATS)) ||
                           (rsp_take_s && (rsp_cnt_r == CNT_W'(NBEATS - 1)));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_req_valid) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = IDLE;
                end
            end
            SAMPLE: begin
                if (legal_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = RESP;
                end
            end
            ISSUE: begin
                if (last_issue_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (rsp_done_s) begin
                    state_s = RESP;
                end else begin
                    state_s = DRAIN;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture; fields are stable from the second valid cycle onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_we_r <= 1'b0;
            store_r <= '0;
        end else if (state_r == SAMPLE) begin
            op_we_r <= (mem_req_opcode == OP_WR);
            store_r <= mem_req_store_data;
        end
    end

    // Registered beat request: beat 0 loaded in SAMPLE, advanced on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_valid_r <= 1'b0;
            bus_addr_r  <= '0;
            bus_we_r    <= 1'b0;
            bus_wdata_r <= '0;
        end else begin
            case (state_r)
                SAMPLE: begin
                    if (legal_s) begin
                        bus_valid_r <= 1'b1;
                        bus_addr_r  <= mem_req_addr & ~ADDR_W'(LINE_BYTES - 1);
                        bus_we_r    <= (mem_req_opcode == OP_WR);
                        bus_wdata_r <= mem_req_store_data[BEAT_BITS-1:0];
                    end
                end
                ISSUE: begin
                    if (last_issue_s) begin
                        bus_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        bus_addr_r  <= bus_addr_r + ADDR_W'(BEAT_BYTES);
                        bus_wdata_r <= beat_of(store_r, issue_cnt_r + CNT_W'(1));
                    end
                end
                default: begin
                    bus_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Issued-beat and received-response counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt_r <= '0;
            rsp_cnt_r   <= '0;
        end else if (state_r == SAMPLE) begin
            issue_cnt_r <= '0;
            rsp_cnt_r   <= '0;
        end else begin
            if (accept_s) begin
                issue_cnt_r <= issue_cnt_r + CNT_W'(1);
            end
            if (rsp_take_s) begin
                rsp_cnt_r <= rsp_cnt_r + CNT_W'(1);
            end
        end
    end

    // Line assembly; write requests leave the previous read line in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_r <= '0;
        end else if ((state_r == SAMPLE) && !legal_s) begin
            line_r <= '0;
        end else if (rsp_take_s && !op_we_r) begin
            for (int i = 0; i < NBEATS; i++) begin
                if (rsp_cnt_r == CNT_W'(i)) begin
                    line_r[i*BEAT_BITS +: BEAT_BITS] <= bus_rsp_rdata;
                end
            end
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err_r <= 1'b0;
        end else if (((state_r == SAMPLE) && !legal_s) || unsolicited_s) begin
            proto_err_r <= 1'b1;
        end
    end

    // Response pulse, registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= (state_s == RESP);
        end
    end

`ifdef MEM_BRIDGE_STATS_EN
    logic [63:0] stat_rd_r;
    logic [63:0] stat_wr_r;

    // Completed line counters; illegal opcodes reach RESP from SAMPLE and
    // are therefore never counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_rd_r <= 64'd0;
            stat_wr_r <= 64'd0;
        end else if ((state_r == DRAIN) && (state_s == RESP)) begin
            if (op_we_r) begin
                stat_wr_r <= stat_wr_r + 64'd1;
            end else begin
                stat_rd_r <= stat_rd_r + 64'd1;
            end
        end
    end

    assign stat_rd_lines = stat_rd_r;
    assign stat_wr_lines = stat_wr_r;
`else
    assign stat_rd_lines = 64'd0;
    assign stat_wr_lines = 64'd0;
`endif

    assign mem_rsp_valid     = rsp_valid_r;
    assign mem_rsp_load_data = line_r;
    assign bus_req_valid     = bus_valid_r;
    assign bus_req_addr      = bus_addr_r;
    assign bus_req_we        = bus_we_r;
    assign bus_req_wdata     = bus_wdata_r;
    assign proto_err         = proto_err_r;

endmodule

// File: doc/mem_beat_bridge.md
# mem_beat_bridge

Converts the core complex's single-line memory port (one cache line per request, held valid until response) into a sequence of narrow word beats on the external memory bus, then reassembles read beats into a full line response. It sits directly downstream of the L1D/L1I arbiter, terminating its memory port. It is the only path from the caches to external memory.

## Interface
- CL_BITS, 128, cache line width in bits (L1D line)
- BEAT_BITS, 32, external bus data width; CL_BITS must be an integer multiple
- ADDR_W, 32, address width (`M_WIDTH)
- NBEATS, CL_BITS/BEAT_BITS (derived, not overridable)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mem_req_valid  in  1  line request, held high until mem_rsp_valid
- mem_req_addr  in  ADDR_W  line byte address
- mem_req_opcode  in  4  4'd4 = line read, 4'd7 = line write
- mem_req_store_data  in  CL_BITS  write line
- mem_rsp_valid  out  1  one-cycle registered response pulse
- mem_rsp_load_data  out  CL_BITS  read line, valid with mem_rsp_valid
- bus_req_valid  out  1  beat request
- bus_req_ready  in  1  bus accepts beat when valid && ready
- bus_req_addr  out  ADDR_W  beat byte address
- bus_req_we  out  1  1 = write beat
- bus_req_wdata  out  BEAT_BITS  write beat data
- bus_rsp_valid  in  1  one response per accepted beat (read data or write ack), in order
- bus_rsp_rdata  in  BEAT_BITS  read beat data
- proto_err  out  1  sticky: unsolicited bus response or illegal opcode
- stat_rd_lines, stat_wr_lines  out  64 each  line counters (see Configuration)

## Operation
- States: IDLE, SAMPLE, ISSUE, DRAIN, RESP.
- IDLE: mem_req_valid=1 -> SAMPLE. Request fields are only guaranteed stable from the second cycle of valid, so nothing is captured in IDLE.
- SAMPLE: capture addr with low log2(CL_BITS/8) bits forced to 0, opcode, and store_data.
  - Legal opcode -> ISSUE, beat counters cleared.
  - Illegal opcode -> RESP with load_data = 0, proto_err set, no bus traffic.
- ISSUE: present beat k (k = issue count).
  - bus_req_addr = base + k*(BEAT_BITS/8).
  - bus_req_we = (opcode==7).
  - bus_req_wdata = store_data[k*BEAT_BITS +: BEAT_BITS].
  - Counter advances on valid&&ready. After beat NBEATS-1 is accepted -> DRAIN.
  - Back-to-back beats; up to NBEATS outstanding.
- Responses are counted in both ISSUE and DRAIN. For reads, beat j is written into line[j*BEAT_BITS +: BEAT_BITS].
- DRAIN: when the response count reaches NBEATS (including a final response arriving this cycle) -> RESP.
- RESP: mem_rsp_valid=1 for exactly one cycle, then -> IDLE.
  - mem_rsp_load_data holds the assembled line until the next SAMPLE. For writes it is unchanged from the previous read.
  - mem_req_valid is not sampled in RESP. Requester deasserts it in this cycle.
- bus_rsp_valid with no outstanding beat: ignored, proto_err set. proto_err clears only on reset.
- Reset, asserted any time (including mid-burst):
  - Immediately forces IDLE and drops bus_req_valid.
  - Clears the counters, line register, proto_err and stats.
  - Responses to beats already outstanding at reset are not tracked.

## Timing
- Reset values: mem_rsp_valid=0, mem_rsp_load_data=0, bus_req_valid=0, bus_req_addr=0, bus_req_we=0, bus_req_wdata=0, proto_err=0, stats=0.
- All outputs are registered. No combinational path from any input to mem_rsp_valid.
- Cycle of mem_req_valid rise = T:
  - SAMPLE at T+1; first beat presented at T+2.
  - With ready=1 and 1-cycle bus response: beats accepted T+2..T+1+NBEATS, last response at T+2+NBEATS, mem_rsp_valid at T+3+NBEATS (T+7 for defaults).
- bus_req_* stay stable while valid && !ready.
- Minimum IDLE-to-IDLE gap between requests: 1 cycle.

## Configuration
- MEM_BRIDGE_STATS_EN defined:
  - stat_rd_lines increments on each read RESP; stat_wr_lines increments on each write RESP.
  - Illegal-opcode responses count in neither.
  - 64-bit counters, wrap modulo 2^64.
- Undefined: both outputs tied to 0 and no counter flops are instantiated.

## Test plan
- Read, addr 0x1004, ready=1, rsp beats 0x11,0x22,0x33,0x44 -> bus addrs 0x1000,0x1004,0x1008,0x100C, we=0; mem_rsp_valid at T+7; load_data = 0x00000044_00000033_00000022_00000011.
- Write, addr 0x2000, store_data = 0xDDDD_CCCC_BBBB_AAAA pattern -> wdata beats AAAA,BBBB,CCCC,DDDD at 0x2000..0x200C, we=1; one rsp pulse after 4 acks; stat_wr_lines=1 (STATS_EN).
- Backpressure: ready low for 3 cycles on beat 2 -> beat-2 addr/data held constant; no skipped or duplicated beats; response 3 cycles later than in the first scenario.
- Opcode 4'd2 -> no bus_req_valid; mem_rsp_valid at T+2 with load_data=0; proto_err=1.
- Unsolicited bus_rsp_valid in IDLE -> proto_err=1; next legal read completes normally.
- Reset asserted after beat 1 accepted -> bus_req_valid=0 without waiting for a clock edge; after release, a new read completes with correct data.
